xgriscv_lsu: RTL and testbench

- Load/store unit: the initiator side of the data-memory interface (dmem).
- Accepts one load/store request from the execute/memory stage over a valid/ready handshake.
- Drives dmem's we/amp/a/wd and samples its combinational read data.
- Returns aligned, sign- or zero-extended load data. Misaligned accesses are split into multiple dmem cycles: two word reads for loads, byte-serial writes for stores.

---
 rtl/xgriscv_lsu_if.sv | 43 ++++
 rtl/xgriscv_lsu.sv | 239 +++++++++++++++++++++++
 tb/tb_xgriscv_lsu.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/xgriscv_lsu_if.sv
// ---------------------------------------------------------------------------
// xgriscv_lsu_if : request/response handshake and data-memory bus of the
// load/store unit, bundled into one interface.
//
//   req_*   : one load/store request (valid/ready), store data right-justified
//   resp_*  : one-cycle completion pulse with extended load data / error flag
//   mem_*   : dmem initiator bus (word-aligned address, byte-lane mask,
//             right-justified write data, combinational read data)
//
// Modports:
//   master : the LSU itself (drives req_ready, resp_*, mem_we/amp/a/wd)
//   slave  : the surrounding pipeline stage plus dmem
// ---------------------------------------------------------------------------
interface xgriscv_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   logic        mem_we;
   logic [3:0]  mem_amp;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   modport master (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_we, mem_amp, mem_a, mem_wd
   );

   modport slave (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_we, mem_amp, mem_a, mem_wd
   );
endinterface

// File: rtl/xgriscv_lsu.sv
// ---------------------------------------------------------------------------
// xgriscv_lsu : load/store unit, initiator side of the data memory.
//
// Accepts one request at a time in IDLE, performs one or more dmem cycles and
// returns a registered one-cycle response. Loads crossing a word boundary are
// done as two word reads; misaligned stores are written one byte per cycle.
// With SPLIT_EN=0 misaligned accesses are rejected with resp_err instead.
//
// Ports:
//   clk    : clock
//   reset  : synchronous active-high reset
//   bus    : xgriscv_lsu_if.master (req_*, resp_*, mem_*)
// ---------------------------------------------------------------------------
module xgriscv_lsu #(
   parameter int XLEN     = 32,
   parameter bit SPLIT_EN = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   xgriscv_lsu_if.master bus
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ACC     = 2'd1;
   localparam logic [1:0] S_LD_HI   = 2'd2;
   localparam logic [1:0] S_ST_BYTE = 2'd3;

   logic [1:0]      state_q, state_d;
   logic            we_q, we_d;
   logic [2:0]      f3_q, f3_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [XLEN-1:0] lo_q, lo_d;          // low word of a split load
   logic            err_q, err_d;
   logic            split_q, split_d;
   logic [2:0]      cnt_q, cnt_d;        // next byte index of a byte-serial store
   logic [2:0]      nb_q, nb_d;          // access size in bytes

   logic            resp_valid_q, resp_valid_d;
   logic            resp_err_q, resp_err_d;
   logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
   logic            mem_we_q, mem_we_d;
   logic [3:0]      mem_amp_q, mem_amp_d;
   logic [XLEN-1:0] mem_a_q, mem_a_d;
   logic [XLEN-1:0] mem_wd_q, mem_wd_d;

   // request classification
   logic [1:0]      req_off;
   logic [2:0]      req_size;
   logic [1:0]      req_size_m1;
   logic [3:0]      req_mask;
   logic            req_f3_ok;
   logic            req_mis;
   logic            req_bad;

   // datapath helpers
   logic [XLEN-1:0] st_addr;
   logic [7:0]      st_byte;
   logic [XLEN-1:0] ld_lo, ld_hi, ld_sh, ld_data;
   logic [5:0]      ld_shamt;

   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] v);
      case (f3)
         3'b000:  extend = {{24{v[7]}}, v[7:0]};
         3'b001:  extend = {{16{v[15]}}, v[15:0]};
         3'b100:  extend = {24'd0, v[7:0]};
         3'b101:  extend = {16'd0, v[15:0]};
         default: extend = v;
      endcase
   endfunction

   assign bus.req_ready  = (state_q == S_IDLE) && !reset;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_amp    = mem_amp_q;
   assign bus.mem_a      = mem_a_q;
   assign bus.mem_wd     = mem_wd_q;

   always_comb begin
      req_off = bus.req_addr[1:0];
      case (bus.req_funct3[1:0])
         2'b00:   begin req_size = 3'd1; req_mask = 4'b0001; end
         2'b01:   begin req_size = 3'd2; req_mask = 4'b0011; end
         default: begin req_size = 3'd4; req_mask = 4'b1111; end
      endcase
      req_size_m1 = req_size[1:0] - 2'd1;
      if (bus.req_we) begin
         req_f3_ok = (bus.req_funct3 < 3'd3);
         // stores must be naturally aligned to go out as one masked write
         req_mis   = (req_off & req_size_m1) != 2'd0;
      end else begin
         req_f3_ok = (bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
         // loads only need splitting when their bytes leave the word
         req_mis   = ({1'b0, req_off} + req_size) > 3'd4;
      end
      req_bad = !req_f3_ok || (req_mis && (SPLIT_EN == 1'b0));
   end

   // byte k of a byte-serial store
   assign st_addr = addr_q + XLEN'(cnt_q);
   assign st_byte = wdata_q[{cnt_q[1:0], 3'b000} +: 8];

   // {hi,lo} >> 8*offset; shifting a 32-bit value by 32 yields zero, which
   // covers the aligned case where hi contributes nothing
   assign ld_lo    = (state_q == S_LD_HI) ? lo_q : bus.mem_rd;
   assign ld_hi    = (state_q == S_LD_HI) ? bus.mem_rd : '0;
   assign ld_shamt = {1'b0, addr_q[1:0], 3'b000};
   assign ld_sh    = (ld_lo >> ld_shamt) | (ld_hi << (6'd32 - ld_shamt));
   assign ld_data  = extend(f3_q, ld_sh);

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      f3_d         = f3_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      lo_d         = lo_q;
      err_d        = err_q;
      split_d      = split_q;
      cnt_d        = cnt_q;
      nb_d         = nb_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = '0;
      mem_we_d     = 1'b0;
      mem_amp_d    = 4'b0000;
      mem_a_d      = mem_a_q;
      mem_wd_d     = mem_wd_q;

      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               f3_d    = bus.req_funct3;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               err_d   = req_bad;
               split_d = !bus.req_we && req_mis;
               nb_d    = req_size;
               cnt_d   = 3'd1;
               state_d = S_ACC;
               // rejected requests leave the memory bus untouched
               if (!req_bad) begin
                  mem_a_d = {bus.req_addr[XLEN-1:2], 2'b00};
                  if (bus.req_we && req_mis) begin
                     state_d   = S_ST_BYTE;
                     mem_we_d  = 1'b1;
                     mem_amp_d = 4'b0001 << req_off;
                     mem_wd_d  = {{(XLEN-8){1'b0}}, bus.req_wdata[7:0]};
                  end else if (bus.req_we) begin
                     mem_we_d  = 1'b1;
                     mem_amp_d = req_mask << req_off;
                     mem_wd_d  = bus.req_wdata;
                  end
               end
            end
         end
         S_ACC: begin
            if (err_q) begin
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
               state_d      = S_IDLE;
            end else if (we_q) begin
               resp_valid_d = 1'b1;
               state_d      = S_IDLE;
            end else if (split_q) begin
               lo_d    = bus.mem_rd;
               mem_a_d = {addr_q[XLEN-1:2] + (XLEN-2)'(1), 2'b00};
               state_d = S_LD_HI;
            end else begin
               resp_valid_d = 1'b1;
               resp_rdata_d = ld_data;
               state_d      = S_IDLE;
            end
         end
         S_LD_HI: begin
            resp_valid_d = 1'b1;
            resp_rdata_d = ld_data;
            state_d      = S_IDLE;
         end
         S_ST_BYTE: begin
            if (cnt_q == nb_q) begin
               resp_valid_d = 1'b1;
               state_d      = S_IDLE;
            end else begin
               mem_we_d  = 1'b1;
               mem_a_d   = {st_addr[XLEN-1:2], 2'b00};
               mem_amp_d = 4'b0001 << st_addr[1:0];
               mem_wd_d  = {{(XLEN-8){1'b0}}, st_byte};
               cnt_d     = cnt_q + 3'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         we_q         <= 1'b0;
         f3_q         <= 3'd0;
         addr_q       <= '0;
         wdata_q      <= '0;
         lo_q         <= '0;
         err_q        <= 1'b0;
         split_q      <= 1'b0;
         cnt_q        <= 3'd0;
         nb_q         <= 3'd0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         mem_we_q     <= 1'b0;
         mem_amp_q    <= 4'b0000;
         mem_a_q      <= '0;
         mem_wd_q     <= '0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         f3_q         <= f3_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         lo_q         <= lo_d;
         err_q        <= err_d;
         split_q      <= split_d;
         cnt_q        <= cnt_d;
         nb_q         <= nb_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         mem_we_q     <= mem_we_d;
         mem_amp_q    <= mem_amp_d;
         mem_a_q      <= mem_a_d;
         mem_wd_q     <= mem_wd_d;
      end
   end

endmodule

// File: tb/tb_xgriscv_lsu.sv
// ---------------------------------------------------------------------------
// tb_xgriscv_lsu : directed bench for xgriscv_lsu. A small byte-lane dmem
// model sits behind the SPLIT_EN=1 instance; a second SPLIT_EN=0 instance
// sees a constant read word. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_xgriscv_lsu;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   xgriscv_lsu_if bus ();
   xgriscv_lsu_if bus2 ();

   xgriscv_lsu #(.XLEN(32), .SPLIT_EN(1'b1)) dut  (.clk(clk), .reset(reset), .bus(bus));
   xgriscv_lsu #(.XLEN(32), .SPLIT_EN(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

   // dmem model: combinational read, lane-masked write of right-justified data
   logic [31:0] mem [0:255];
   int          n_writes  = 0;
   int          n_writes2 = 0;
   int          lo_lane;

   assign bus.mem_rd  = mem[bus.mem_a[9:2]];
   assign bus2.mem_rd = 32'hA5A5A5A5;

   always @(posedge clk) begin
      if (bus.mem_we) begin
         lo_lane = 0;
         if (bus.mem_amp[0])      lo_lane = 0;
         else if (bus.mem_amp[1]) lo_lane = 1;
         else if (bus.mem_amp[2]) lo_lane = 2;
         else                     lo_lane = 3;
         for (int l = 0; l < 4; l++)
            if (bus.mem_amp[l])
               mem[bus.mem_a[9:2]][8*l +: 8] <= bus.mem_wd[8*(l-lo_lane) +: 8];
         n_writes <= n_writes + 1;
      end
      if (bus2.mem_we) n_writes2 <= n_writes2 + 1;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // per-cycle log of one transaction; index i = cycle T+i
   logic [31:0] a_l   [1:10];
   logic [31:0] wd_l  [1:10];
   logic [3:0]  amp_l [1:10];
   logic        we_l  [1:10];
   logic        rdy_l [1:10];
   logic [31:0] rd_l;
   logic        err_l;
   int          lat;

   task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      check_eq("accept_ready", 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      lat   = 0;
      rd_l  = 32'hX;
      err_l = 1'bX;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         we_l[i]  = bus.mem_we;
         amp_l[i] = bus.mem_amp;
         a_l[i]   = bus.mem_a;
         wd_l[i]  = bus.mem_wd;
         rdy_l[i] = bus.req_ready;
         if (bus.resp_valid) begin
            lat   = i;
            rd_l  = bus.resp_rdata;
            err_l = bus.resp_err;
            break;
         end
      end
      $display("txn we=%0d f3=%0d addr=%h wdata=%h lat=%0d rdata=%h err=%0d",
               we, f3, a, wd, lat, rd_l, err_l);
   endtask

   task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] exp);
      run(1'b0, f3, a, 32'd0);
      check_eq(tag, rd_l, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int  w0;
   logic seen;

   initial begin
      reset           = 1'b1;
      bus.req_valid   = 1'b0;
      bus.req_we      = 1'b0;
      bus.req_funct3  = 3'd0;
      bus.req_addr    = 32'd0;
      bus.req_wdata   = 32'd0;
      bus2.req_valid  = 1'b0;
      bus2.req_we     = 1'b0;
      bus2.req_funct3 = 3'd0;
      bus2.req_addr   = 32'd0;
      bus2.req_wdata  = 32'd0;

      // reset state
      repeat (3) @(negedge clk);
      check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
      check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);
      check_eq("rst_mem_amp", 32'(bus.mem_amp), 32'd0);
      check_eq("rst_mem_a", bus.mem_a, 32'd0);
      check_eq("rst_mem_wd", bus.mem_wd, 32'd0);
      reset = 1'b0;

      // aligned store then load
      run(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
      check_eq("sw_lat", 32'(lat), 32'd2);
      check_eq("sw_we", 32'(we_l[1]), 32'd1);
      check_eq("sw_amp", 32'(amp_l[1]), 32'hF);
      check_eq("sw_a", a_l[1], 32'h100);
      check_eq("sw_wd", wd_l[1], 32'hDEADBEEF);
      check_eq("sw_rdata", rd_l, 32'd0);
      check_eq("sw_err", 32'(err_l), 32'd0);
      run(1'b0, 3'b010, 32'h100, 32'd0);
      check_eq("lw_lat", 32'(lat), 32'd2);
      check_eq("lw_rdata", rd_l, 32'hDEADBEEF);
      check_eq("lw_we", 32'(we_l[1]), 32'd0);
      check_eq("lw_amp", 32'(amp_l[1]), 32'd0);
      check_eq("lw_ready_at_resp", 32'(rdy_l[2]), 32'd1);

      // extension
      run(1'b1, 3'b010, 32'h100, 32'h80FF1234);
      load_chk("lb_103", 3'b000, 32'h103, 32'hFFFFFF80);
      load_chk("lbu_103", 3'b100, 32'h103, 32'h00000080);
      load_chk("lh_102", 3'b001, 32'h102, 32'hFFFF80FF);
      load_chk("lhu_100", 3'b101, 32'h100, 32'h00001234);

      // split load
      run(1'b1, 3'b010, 32'h100, 32'h44332211);
      run(1'b1, 3'b010, 32'h104, 32'h88776655);
      run(1'b0, 3'b010, 32'h102, 32'd0);
      check_eq("splitld_lat", 32'(lat), 32'd3);
      check_eq("splitld_a1", a_l[1], 32'h100);
      check_eq("splitld_a2", a_l[2], 32'h104);
      check_eq("splitld_rdy1", 32'(rdy_l[1]), 32'd0);
      check_eq("splitld_rdy2", 32'(rdy_l[2]), 32'd0);
      check_eq("splitld_rdata", rd_l, 32'h66554433);

      // split halfword store
      run(1'b1, 3'b001, 32'h103, 32'h0000ABCD);
      check_eq("splitsh_lat", 32'(lat), 32'd3);
      check_eq("splitsh_a1", a_l[1], 32'h100);
      check_eq("splitsh_amp1", 32'(amp_l[1]), 32'h8);
      check_eq("splitsh_wd1", wd_l[1], 32'h000000CD);
      check_eq("splitsh_a2", a_l[2], 32'h104);
      check_eq("splitsh_amp2", 32'(amp_l[2]), 32'h1);
      check_eq("splitsh_wd2", wd_l[2], 32'h000000AB);
      check_eq("splitsh_we2", 32'(we_l[2]), 32'd1);
      load_chk("splitsh_rb100", 3'b010, 32'h100, 32'hCD332211);
      load_chk("splitsh_rb104", 3'b010, 32'h104, 32'h887766AB);

      // split word store, four byte writes
      run(1'b1, 3'b010, 32'h108, 32'd0);
      run(1'b1, 3'b010, 32'h105, 32'hCAFEF00D);
      check_eq("splitsw_lat", 32'(lat), 32'd5);
      check_eq("splitsw_amp1", 32'(amp_l[1]), 32'h2);
      check_eq("splitsw_a4", a_l[4], 32'h108);
      check_eq("splitsw_amp4", 32'(amp_l[4]), 32'h1);
      check_eq("splitsw_wd4", wd_l[4], 32'h000000CA);
      load_chk("splitsw_rb104", 3'b010, 32'h104, 32'hFEF00DAB);
      load_chk("splitsw_rb108", 3'b010, 32'h108, 32'h000000CA);

      // split load wrapping past the top of the address space
      run(1'b1, 3'b010, 32'hFFFFFFFC, 32'hAABBCCDD);
      run(1'b1, 3'b010, 32'h00000000, 32'h11223344);
      run(1'b0, 3'b010, 32'hFFFFFFFE, 32'd0);
      check_eq("wrap_a1", a_l[1], 32'hFFFFFFFC);
      check_eq("wrap_a2", a_l[2], 32'h00000000);
      check_eq("wrap_rdata", rd_l, 32'h3344AABB);

      // invalid funct3
      w0 = n_writes;
      run(1'b0, 3'b011, 32'h100, 32'd0);
      check_eq("errld_lat", 32'(lat), 32'd2);
      check_eq("errld_err", 32'(err_l), 32'd1);
      check_eq("errld_rdata", rd_l, 32'd0);
      check_eq("errld_we", 32'(we_l[1]), 32'd0);
      @(negedge clk);
      check_eq("err_pulse_valid", 32'(bus.resp_valid), 32'd0);
      check_eq("err_pulse_err", 32'(bus.resp_err), 32'd0);
      run(1'b1, 3'b011, 32'h100, 32'h12345678);
      check_eq("errst_err", 32'(err_l), 32'd1);
      check_eq("errst_lat", 32'(lat), 32'd2);
      check_eq("err_no_writes", 32'(n_writes - w0), 32'd0);

      // SPLIT_EN=0 instance: misaligned lw rejected, in-word lh served
      @(negedge clk);
      bus2.req_valid  = 1'b1;
      bus2.req_we     = 1'b0;
      bus2.req_funct3 = 3'b010;
      bus2.req_addr   = 32'h102;
      @(posedge clk);
      #1 bus2.req_valid = 1'b0;
      @(negedge clk);
      check_eq("nosplit_t1_valid", 32'(bus2.resp_valid), 32'd0);
      @(negedge clk);
      check_eq("nosplit_valid", 32'(bus2.resp_valid), 32'd1);
      check_eq("nosplit_err", 32'(bus2.resp_err), 32'd1);
      check_eq("nosplit_rdata", bus2.resp_rdata, 32'd0);
      check_eq("nosplit_mem_a", bus2.mem_a, 32'd0);
      check_eq("nosplit_writes", 32'(n_writes2), 32'd0);
      $display("txn dut2 lw addr=00000102 err=%0d", bus2.resp_err);
      bus2.req_valid  = 1'b1;
      bus2.req_funct3 = 3'b001;
      bus2.req_addr   = 32'h101;
      @(posedge clk);
      #1 bus2.req_valid = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("nosplit_lh_valid", 32'(bus2.resp_valid), 32'd1);
      check_eq("nosplit_lh_err", 32'(bus2.resp_err), 32'd0);
      check_eq("nosplit_lh_rdata", bus2.resp_rdata, 32'hFFFFA5A5);
      $display("txn dut2 lh addr=00000101 rdata=%h", bus2.resp_rdata);

      // reset in the middle of a byte-serial store
      run(1'b1, 3'b010, 32'h100, 32'd0);
      run(1'b1, 3'b010, 32'h104, 32'd0);
      w0 = n_writes;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h101;
      bus.req_wdata  = 32'h11223344;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_eq("rstmid_ready", 32'(bus.req_ready), 32'd1);
      check_eq("rstmid_mem_we", 32'(bus.mem_we), 32'd0);
      seen = bus.resp_valid;
      repeat (5) begin
         @(negedge clk);
         seen = seen | bus.resp_valid;
      end
      check_eq("rstmid_no_resp", 32'(seen), 32'd0);
      check_eq("rstmid_writes", 32'(n_writes - w0), 32'd1);
      check_eq("rstmid_word100", mem[8'h40], 32'h00004400);
      check_eq("rstmid_word104", mem[8'h41], 32'h00000000);
      $display("txn sw addr=00000101 interrupted by reset writes=%0d", n_writes - w0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
